// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write path.
//   XLEN    : datapath width
//   REG_CNT : number of architectural registers
//   REG_AW  : register address width
//   state_e : arbiter control states (INIT sequence, then RUN)
package rf_pkg;

    localparam int XLEN    = 32;
    localparam int REG_CNT = 32;
    localparam int REG_AW  = 5;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bus between the writeback requesters and the register-file write arbiter.
//   req_valid / req_ready : per-requester handshake (transfer on valid & ready)
//   req_rd / req_data     : packed per-requester destination and data
//   write_reg / target_reg / write_rd_data : registered register-file write port
//   init_busy             : high while the post-reset init sequence runs
// Modports: master = requester/register-file side, slave = arbiter side.
interface regfile_write_arbiter_if
    import rf_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int W     = XLEN
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*REG_AW-1:0] req_rd;
    logic [N_REQ*W-1:0]      req_data;
    logic                    write_reg;
    logic [REG_AW-1:0]       target_reg;
    logic [W-1:0]            write_rd_data;
    logic                    init_busy;

    modport master (
        output req_valid, req_rd, req_data,
        input  req_ready, write_reg, target_reg, write_rd_data, init_busy
    );

    modport slave (
        input  req_valid, req_rd, req_data,
        output req_ready, write_reg, target_reg, write_rd_data, init_busy
    );
endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   valid     : request vector
//   ptr       : highest-priority index this cycle
//   grant     : one-hot grant (zero when nothing is valid)
//   grant_idx : binary index of the granted requester
//   grant_any : at least one request granted
module rr_arbiter #(
    parameter  int N_REQ = 2,
    localparam int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PW-1:0]    grant_idx,
    output logic             grant_any
);

    // Scan from ptr upward with wrap; the first valid index found wins.
    always_comb begin
        int idx;
        // NOTE: every output gets a default before the loop, so no path
        // leaves a signal unassigned and no latch is inferred.
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int off = 0; off < N_REQ; off++) begin
            idx = int'(ptr) + off;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!grant_any && valid[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = PW'(idx);
                grant_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owner of the register-file write port. After reset it writes x0=0 and
// x1..x31=INIT_VAL (one per cycle), then shares the port among N_REQ
// writeback requesters with round-robin arbitration.
//   clk  : clock, all state on posedge
//   rst  : asynchronous, active-low reset
//   bus  : requester handshakes plus registered register-file write outputs
module regfile_write_arbiter
    import rf_pkg::*;
#(
    parameter int          N_REQ    = 2,
    parameter int          W        = XLEN,
    parameter logic [W-1:0] INIT_VAL = {W{1'b1}}
) (
    input  logic                    clk,
    input  logic                    rst,
    regfile_write_arbiter_if.slave  bus
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e            state_q, state_d;
    logic [REG_AW-1:0] init_cnt_q, init_cnt_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic              write_reg_q, write_reg_d;
    logic [REG_AW-1:0] target_reg_q, target_reg_d;
    logic [W-1:0]      write_rd_data_q, write_rd_data_d;

    logic [N_REQ-1:0]  grant;
    logic [PW-1:0]     grant_idx;
    logic              grant_any;
    logic [REG_AW-1:0] sel_rd;
    logic [W-1:0]      sel_data;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
        .valid     (bus.req_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign sel_rd   = bus.req_rd[int'(grant_idx)*REG_AW +: REG_AW];
    assign sel_data = bus.req_data[int'(grant_idx)*W +: W];

    always_comb begin
        state_d         = state_q;
        init_cnt_d      = init_cnt_q;
        rr_ptr_d        = rr_ptr_q;
        write_reg_d     = 1'b0;
        target_reg_d    = target_reg_q;
        write_rd_data_d = write_rd_data_q;

        unique case (state_q)
            INIT: begin
                write_reg_d     = 1'b1;
                target_reg_d    = init_cnt_q;
                write_rd_data_d = (init_cnt_q == '0) ? '0 : INIT_VAL;
                init_cnt_d      = init_cnt_q + 1'b1;
                if (init_cnt_q == REG_AW'(REG_CNT - 1)) state_d = RUN;
            end
            RUN: begin
                if (grant_any) begin
                    // x0 requests still consume the grant but never write.
                    write_reg_d     = (sel_rd != '0);
                    target_reg_d    = sel_rd;
                    write_rd_data_d = sel_data;
                    rr_ptr_d        = (grant_idx == PW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
                end
            end
            default: state_d = INIT;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= INIT;
            init_cnt_q      <= '0;
            rr_ptr_q        <= '0;
            write_reg_q     <= 1'b0;
            target_reg_q    <= '0;
            write_rd_data_q <= '0;
        end else begin
            state_q         <= state_d;
            init_cnt_q      <= init_cnt_d;
            rr_ptr_q        <= rr_ptr_d;
            write_reg_q     <= write_reg_d;
            target_reg_q    <= target_reg_d;
            write_rd_data_q <= write_rd_data_d;
        end
    end

    assign bus.req_ready     = (state_q == RUN) ? grant : '0;
    assign bus.init_busy     = (state_q == INIT);
    assign bus.write_reg     = write_reg_q;
    assign bus.target_reg    = target_reg_q;
    assign bus.write_rd_data = write_rd_data_q;

endmodule
